// File: rtl/spi_pixel_writer.sv
// spi_pixel_writer: moves 16-bit SPI words into the clk domain, decodes pixel
// and command words, and drives the HUB75 frame buffer write port.
// Optional feature macro: SPI_PIXEL_WRITER_DOUBLE_BUFFER_EN (bank ping-pong).
module spi_pixel_writer #(
  parameter int ADDR_WIDTH  = 11,
  parameter int PIXEL_COUNT = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           data,
  input  logic                  pixel_clock,
  output logic                  fb_we,
  output logic [ADDR_WIDTH:0]   fb_addr,
  output logic [14:0]           fb_data,
  output logic                  frame_done,
  output logic                  display_bank,
  output logic [7:0]            brightness,
  output logic                  sync_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    STREAM    = 1'b1
  } state_t;

  state_t                state_q;
  logic                  s1_q, s2_q, s3_q;
  logic [ADDR_WIDTH-1:0] pix_addr_q;
  logic                  fb_we_q;
  logic [ADDR_WIDTH:0]   fb_addr_q;
  logic [14:0]           fb_data_q;
  logic                  frame_done_q;
  logic [7:0]            brightness_q;
  logic                  sync_error_q;
  logic                  write_bank;

  // Falling edge of the synchronised pixel_clock marks a new stable word.
  logic word_strobe;
  logic is_pixel, is_frame_start, is_brightness, is_last_pix;
  assign word_strobe    = s3_q & ~s2_q;
  assign is_pixel       = ~data[15];
  assign is_frame_start = (data == 16'h8000);
  assign is_brightness  = (data[15:14] == 2'b11);
  assign is_last_pix    = (pix_addr_q == LAST_ADDR);

`ifdef SPI_PIXEL_WRITER_DOUBLE_BUFFER_EN
  logic write_bank_q, display_bank_q;
  logic bank_swap;
  assign bank_swap = word_strobe & (state_q == STREAM) & is_pixel & is_last_pix;

  // Ping-pong banks: both flip together when a frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_bank_q   <= 1'b0;
      display_bank_q <= 1'b1;
    end else if (bank_swap) begin
      write_bank_q   <= ~write_bank_q;
      display_bank_q <= ~display_bank_q;
    end else begin
      write_bank_q   <= write_bank_q;
      display_bank_q <= display_bank_q;
    end
  end

  assign write_bank   = write_bank_q;
  assign display_bank = display_bank_q;
`else
  // Single buffer: frames are written in place.
  assign write_bank   = 1'b0;
  assign display_bank = 1'b0;
`endif

  // Synchroniser, word decode FSM and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s3_q         <= 1'b1;
      state_q      <= WAIT_SYNC;
      pix_addr_q   <= ADDR_ZERO;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= 15'h0000;
      frame_done_q <= 1'b0;
      brightness_q <= 8'hFF;
      sync_error_q <= 1'b0;
    end else begin
      s1_q         <= pixel_clock;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (word_strobe) begin
        if (is_brightness) begin
          brightness_q <= data[7:0];
        end else if (is_frame_start) begin
          // Also abandons any partial frame without signalling completion.
          pix_addr_q <= ADDR_ZERO;
          state_q    <= STREAM;
        end else if (is_pixel) begin
          case (state_q)
            WAIT_SYNC: begin
              sync_error_q <= 1'b1;
            end
            STREAM: begin
              fb_we_q   <= 1'b1;
              fb_addr_q <= {write_bank, pix_addr_q};
              fb_data_q <= data[14:0];
              if (is_last_pix) begin
                frame_done_q <= 1'b1;
                pix_addr_q   <= ADDR_ZERO;
                state_q      <= WAIT_SYNC;
              end else begin
                pix_addr_q <= pix_addr_q + ADDR_ONE;
              end
            end
            default: begin
              state_q <= WAIT_SYNC;
            end
          endcase
        end else begin
          // Unrecognised command words are ignored.
          state_q <= state_q;
        end
      end
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign frame_done = frame_done_q;
  assign brightness = brightness_q;
  assign sync_error = sync_error_q;

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Directed self-checking bench for spi_pixel_writer with a write scoreboard.
module tb_spi_pixel_writer;

  localparam int ADDR_WIDTH  = 11;
  localparam int PIXEL_COUNT = 2048;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic        pixel_clock;
  logic        fb_we;
  logic [11:0] fb_addr;
  logic [14:0] fb_data;
  logic        frame_done;
  logic        display_bank;
  logic [7:0]  brightness;
  logic        sync_error;

  spi_pixel_writer #(.ADDR_WIDTH(ADDR_WIDTH), .PIXEL_COUNT(PIXEL_COUNT)) dut (
    .clk(clk), .reset(reset), .data(data), .pixel_clock(pixel_clock),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done),
    .display_bank(display_bank), .brightness(brightness), .sync_error(sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fd;
    logic [11:0] addr;
    logic [14:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  // Reference model state
  logic        m_stream;
  logic [10:0] m_addr;
  logic        m_wbank;
  logic        m_dbank;
  logic [7:0]  m_bright;
  logic        m_serr;

`ifdef SPI_PIXEL_WRITER_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stream = 1'b0;
    m_addr   = 11'd0;
    m_wbank  = 1'b0;
    m_dbank  = DB;
    m_bright = 8'hFF;
    m_serr   = 1'b0;
  endtask

  task automatic model_word(input logic [15:0] w);
    wr_t e;
    if (w[15:14] == 2'b11) begin
      m_bright = w[7:0];
    end else if (w == 16'h8000) begin
      m_addr   = 11'd0;
      m_stream = 1'b1;
    end else if (w[15] == 1'b0) begin
      if (!m_stream) begin
        m_serr = 1'b1;
      end else begin
        e.fd   = (m_addr == 11'(PIXEL_COUNT - 1));
        e.addr = {m_wbank, m_addr};
        e.d    = w[14:0];
        exp_q.push_back(e);
        if (e.fd) begin
          m_addr   = 11'd0;
          m_stream = 1'b0;
          if (DB) begin
            m_wbank = ~m_wbank;
            m_dbank = ~m_dbank;
          end
        end else begin
          m_addr = m_addr + 11'd1;
        end
      end
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (fb_we === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fb_addr", 32'(fb_addr), 32'(e.addr));
        chk("fb_data", 32'(fb_data), 32'(e.d));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end else if (frame_done !== 1'b0) begin
      chk("frame_done_without_write", 32'(fb_we), 32'd1);
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_brightness"}, 32'(brightness), 32'(m_bright));
    chk({tag, "_sync_error"}, 32'(sync_error), 32'(m_serr));
    chk({tag, "_display_bank"}, 32'(display_bank), 32'(m_dbank));
  endtask

  // One SPI word: 3 clks low, 3 clks high; returns at posedge+1.
  task automatic send_word(input logic [15:0] w);
    data = w;
    model_word(w);
    pixel_clock = 1'b0;
    repeat (3) @(posedge clk);
    #1 pixel_clock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Same as send_word but checks that the write lands right after edge 3.
  task automatic send_word_lat(input logic [15:0] w);
    data = w;
    model_word(w);
    pixel_clock = 1'b0;
    @(posedge clk); @(negedge clk); chk("lat_edge1", 32'(fb_we), 32'd0);
    @(posedge clk); @(negedge clk); chk("lat_edge2", 32'(fb_we), 32'd0);
    @(posedge clk); @(negedge clk); chk("lat_edge3", 32'(fb_we), 32'd1);
    @(posedge clk);
    #1 pixel_clock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fb_we"}, 32'(fb_we), 32'd0);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    chk({tag, "_fb_data"}, 32'(fb_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1;
    pixel_clock = 1'b1;
    data = 16'h0000;
    @(posedge clk); #1;
    do_reset();

    // Idle: pixel_clock high for 20 clks, nothing must be written.
    repeat (20) @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // First two pixels with latency check.
    send_word(16'h8000);
    send_word_lat(16'h7C00);
    send_word_lat(16'h03E0);
    check_state("two_pix");

    // Full frame plus one extra pixel.
    do_reset();
    send_word(16'h8000);
    for (int i = 0; i < PIXEL_COUNT; i++) send_word({1'b0, 15'(i * 7 + 3)});
    check_state("frame1");
    send_word(16'h1234);
    check_state("extra_pixel");
    chk("extra_pixel_serr", 32'(sync_error), 32'd1);

    // Second full frame: other bank when double-buffered.
    send_word(16'h8000);
    for (int i = 0; i < PIXEL_COUNT; i++) send_word({1'b0, 15'(i ^ 15'h2A5A)});
    check_state("frame2");

    // Abandoned partial frame restarts at address 0.
    do_reset();
    send_word(16'h8000);
    for (int i = 0; i < 5; i++) send_word({1'b0, 15'(16'h0100 + i)});
    send_word(16'h8000);
    send_word(16'h0555);
    chk("restart_addr", 32'(fb_addr[10:0]), 32'd0);
    check_state("restart");

    // Brightness in STREAM, ignored command, continue streaming.
    send_word(16'hC042);
    check_state("bright_stream");
    send_word(16'h8123);
    check_state("ignored_cmd");
    send_word(16'h0AAA);
    chk("after_cmds_addr", 32'(fb_addr[10:0]), 32'd1);

    // Brightness in WAIT_SYNC.
    do_reset();
    send_word(16'hC017);
    check_state("bright_wait");
    chk("bright_wait_val", 32'(brightness), 32'h17);

    // Reset between pixel 3 and 4.
    send_word(16'h8000);
    for (int i = 0; i < 3; i++) send_word({1'b0, 15'(16'h0040 + i)});
    do_reset();
    check_reset_outputs("mid_reset");
    send_word(16'h0004);
    check_state("after_reset_pix");
    chk("after_reset_serr", 32'(sync_error), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pixel_writer.md
Name: spi_pixel_writer

Overview:
- Consumes the 16-bit word stream from the SPI receive stage (`data`, `pixel_clock`, both in the spi_clk domain) and moves it into the system `clk` domain.
- Decodes each word as either a pixel or a command.
- Drives the write port of the HUB75 frame buffer RAM with a sequential pixel address.
- Supplies frame-complete and brightness information to the panel scan logic.

Parameters:
- ADDR_WIDTH, 11, width of the pixel address inside one frame (64x32 panel = 2048 pixels).
- PIXEL_COUNT, 2048, pixels per frame; the last pixel address is PIXEL_COUNT-1.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  16  last complete SPI word; asynchronous to clk.
- pixel_clock  input  1  word strobe from the SPI stage; asynchronous to clk; `data` is stable while it is low.
- fb_we  output  1  frame buffer write enable, one-clk pulse.
- fb_addr  output  ADDR_WIDTH+1  write address; MSB is the bank bit.
- fb_data  output  15  pixel colour, RGB555 (data[14:0]).
- frame_done  output  1  one-clk pulse after the final pixel of a frame is written.
- display_bank  output  1  bank the scan logic reads from.
- brightness  output  8  global brightness value.
- sync_error  output  1  sticky flag; a pixel word arrived while not synced.

Behaviour:
- Clock-domain crossing:
  - pixel_clock passes through a 2-FF synchroniser (s1, s2) plus a history flop s3.
  - s1, s2 and s3 all reset to 1.
  - word_strobe = s3 & ~s2, i.e. a falling edge of the synchronised pixel_clock.
  - `data` is sampled directly on the clk edge where word_strobe is true. It is stable at that point because the SPI stage updated it 7 spi_clk cycles earlier.
  - Requirement: clk frequency >= 2x spi_clk.
- Latency: counting the clk edge at which s1 first samples pixel_clock low as edge 1, the word is acted on at edge 3. For a pixel word, fb_we is high for the single cycle following edge 3.
- Word decode:
  - data[15]=0: pixel word, colour = data[14:0].
  - data=16'h8000: FRAME_START.
  - data[15:14]=2'b11: SET_BRIGHTNESS, value = data[7:0].
  - Any other word with data[15]=1 is ignored. It changes no state and does not set an error.
- State machine (state register resets to WAIT_SYNC):
  - WAIT_SYNC:
    - FRAME_START: pixel address := 0, go to STREAM.
    - Pixel word: discard, set sync_error, no write.
    - SET_BRIGHTNESS: applied.
  - STREAM:
    - Pixel word: fb_we=1, fb_addr={write_bank, pix_addr}, fb_data=data[14:0].
    - If pix_addr == PIXEL_COUNT-1: this write is performed, frame_done pulses in the same cycle as fb_we, the bank swap is applied (see Optional Feature), pix_addr := 0, go to WAIT_SYNC.
    - Otherwise pix_addr increments by 1.
    - FRAME_START: abandon the partial frame, pix_addr := 0, stay in STREAM, no frame_done, no bank swap.
    - SET_BRIGHTNESS: applied; pix_addr is unchanged.
- pix_addr never wraps past PIXEL_COUNT-1. A frame longer than PIXEL_COUNT words is impossible because the FSM leaves STREAM after the final pixel.
- At most one word is processed per word_strobe.
- Reset values: fb_we=0, fb_addr=0, fb_data=0, frame_done=0, display_bank=0, write_bank=0, brightness=8'hFF, sync_error=0, pix_addr=0.
- sync_error clears only on reset.
- Reset asserted mid-frame returns the block to WAIT_SYNC with all outputs at reset values.
- Reset has priority over a simultaneous word_strobe; that word is lost.
- fb_addr and fb_data hold their last values when fb_we=0.

Optional Feature:
- Macro: SPI_PIXEL_WRITER_DOUBLE_BUFFER_EN.
- Defined:
  - write_bank resets to 0 and display_bank resets to 1.
  - On each frame_done, both toggle in the same cycle, so the scan logic always reads the completed bank.
  - fb_addr MSB = write_bank.
- Undefined:
  - write_bank and display_bank are tied to 0, and fb_addr MSB = 0.
  - Frames write in place (tearing is accepted).
  - frame_done behaviour is unchanged.

Test Plan:
- Reset, then pixel_clock held high for 20 clks -> fb_we never asserted; all outputs at reset values.
- Send 16'h8000, then pixel words 16'h7C00 and 16'h03E0 -> fb_we pulses twice: addr 0 / data 15'h7C00, then addr 1 / data 15'h03E0. Each pulse arrives at edge 3 after pixel_clock falls.
- Send 16'h8000 then 2048 pixels -> frame_done pulses coincident with the write to addr 2047; state returns to WAIT_SYNC; a 2049th pixel produces no write and sets sync_error=1.
- With SPI_PIXEL_WRITER_DOUBLE_BUFFER_EN defined, send two complete frames -> frame 1 writes fb_addr MSB=0, display_bank goes 1->0 at the first frame_done; frame 2 writes MSB=1, display_bank returns to 1.
- 16'h8000, 5 pixels, 16'h8000, 1 pixel -> last write is addr 0; no frame_done in the sequence.
- 16'hC042 in either state -> brightness=8'h42 and pix_addr unchanged; 16'h8123 -> no effect. Assert reset between pixels 3 and 4 -> outputs return to reset values and the next pixel without FRAME_START sets sync_error.
